sparce_mem_resp: RTL and testbench

SPARCE_MEM_RESP -- requirements
Module: sparce_mem_resp

---
 rtl/sparce_mem_resp_pkg.sv | 33 +++
 rtl/sparce_mem_cam.sv | 43 ++++
 rtl/sparce_mem_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_sparce_mem_resp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparce_mem_resp_pkg.sv
// Shared types and default sizes for the sparse address/data responder.
package sparceMemPkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ENTRIES    = 8;

    // Request opcodes; the fourth encoding is deliberately left undefined.
    typedef enum logic [1:0] {
        MEM_READ   = 2'd0,
        MEM_WRITE  = 2'd1,
        MEM_DELETE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        OK   = 2'd0,
        MISS = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } mem_status_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

    // Index width for an n-entry table, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sparce_mem_cam.sv
// Combinational match and free-slot search over the tag table.
module sparce_mem_cam
    import sparceMemPkg::*;
#(
    parameter int ADDR_WIDTH = sparceMemPkg::ADDR_WIDTH,
    parameter int ENTRIES    = sparceMemPkg::ENTRIES,
    localparam int IDX_W     = idx_width(ENTRIES)
) (
    input  logic [ENTRIES-1:0]                 valid,
    input  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] tags,
    input  logic [ADDR_WIDTH-1:0]              addr,
    output logic                               hit,
    output logic [IDX_W-1:0]                   hit_idx,
    output logic [IDX_W-1:0]                   free_idx,
    output logic                               full
);

    logic free_found_s;

    // Scan from index 0 upward so the first match and the lowest free slot win.
    always_comb begin
        hit          = 1'b0;
        hit_idx      = {IDX_W{1'b0}};
        free_idx     = {IDX_W{1'b0}};
        free_found_s = 1'b0;
        full         = &valid;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && valid[i] && (tags[i] == addr)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end else begin
                hit     = hit;
            end
            if (!free_found_s && !valid[i]) begin
                free_found_s = 1'b1;
                free_idx     = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

endmodule

// File: rtl/sparce_mem_resp.sv
// Single-outstanding request responder over a small associative address/data table.
module sparce_mem_resp
    import sparceMemPkg::*;
#(
    parameter int ADDR_WIDTH = sparceMemPkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sparceMemPkg::DATA_WIDTH,
    parameter int ENTRIES    = sparceMemPkg::ENTRIES,
    localparam int IDX_W     = idx_width(ENTRIES),
    localparam int OCC_W     = $clog2(ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  mem_op_e               req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output mem_status_e           rsp_status,
    output logic [OCC_W-1:0]      occupancy
);

    mem_state_e state_r;
    mem_state_e state_next_s;
    logic       ready_r;
    logic       accept_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    mem_op_e               op_r;

    logic [ENTRIES-1:0]                 valid_r;
    logic [ENTRIES-1:0][ADDR_WIDTH-1:0] tag_r;
    logic [ENTRIES-1:0][DATA_WIDTH-1:0] mem_r;
    logic [OCC_W-1:0]                   occ_r;

    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    mem_status_e           rsp_status_r;

    logic             hit_s;
    logic             full_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic [IDX_W-1:0] free_idx_s;

    logic                  tbl_we_s;
    logic [IDX_W-1:0]      tbl_idx_s;
    logic                  set_valid_s;
    logic                  clr_valid_s;
    logic [DATA_WIDTH-1:0] rsp_data_next_s;
    mem_status_e           rsp_status_next_s;

    assign accept_s = req_valid && ready_r;

    sparce_mem_cam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (ENTRIES)
    ) u_cam (
        .valid    (valid_r),
        .tags     (tag_r),
        .addr     (addr_r),
        .hit      (hit_s),
        .hit_idx  (hit_idx_s),
        .free_idx (free_idx_s),
        .full     (full_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = LOOKUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOOKUP: state_next_s = RESP;
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Decode the lookup result into table updates and the response to be latched.
    always_comb begin
        tbl_we_s          = 1'b0;
        tbl_idx_s         = hit_idx_s;
        set_valid_s       = 1'b0;
        clr_valid_s       = 1'b0;
        rsp_data_next_s   = {DATA_WIDTH{1'b0}};
        rsp_status_next_s = OK;
        if (state_r == LOOKUP) begin
            case (op_r)
                MEM_WRITE: begin
                    if (hit_s) begin
                        tbl_we_s        = 1'b1;
                        tbl_idx_s       = hit_idx_s;
                        rsp_data_next_s = data_r;
                    end else if (!full_s) begin
                        tbl_we_s        = 1'b1;
                        tbl_idx_s       = free_idx_s;
                        set_valid_s     = 1'b1;
                        rsp_data_next_s = data_r;
                    end else begin
                        rsp_status_next_s = FULL;
                    end
                end
                MEM_READ: begin
                    if (hit_s) begin
                        rsp_data_next_s = mem_r[hit_idx_s];
                    end else begin
                        rsp_status_next_s = MISS;
                    end
                end
                MEM_DELETE: begin
                    if (hit_s) begin
                        clr_valid_s     = 1'b1;
                        rsp_data_next_s = mem_r[hit_idx_s];
                    end else begin
                        rsp_status_next_s = MISS;
                    end
                end
                default: rsp_status_next_s = ERR;
            endcase
        end else begin
            rsp_status_next_s = OK;
        end
    end

    // Request ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == IDLE);
        end
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
            data_r <= {DATA_WIDTH{1'b0}};
            op_r   <= MEM_READ;
        end else if (accept_s) begin
            addr_r <= req_addr;
            data_r <= req_data;
            op_r   <= req_op;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Table contents and occupancy change only on the LOOKUP->RESP edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_r <= {ENTRIES{1'b0}};
            tag_r   <= {(ENTRIES*ADDR_WIDTH){1'b0}};
            mem_r   <= {(ENTRIES*DATA_WIDTH){1'b0}};
            occ_r   <= {OCC_W{1'b0}};
        end else begin
            if (tbl_we_s) begin
                tag_r[tbl_idx_s] <= addr_r;
                mem_r[tbl_idx_s] <= data_r;
            end else begin
                tag_r <= tag_r;
            end
            if (set_valid_s && (occ_r < OCC_W'(ENTRIES))) begin
                valid_r[tbl_idx_s] <= 1'b1;
                occ_r              <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
            end else if (clr_valid_s && (occ_r != {OCC_W{1'b0}})) begin
                valid_r[tbl_idx_s] <= 1'b0;
                occ_r              <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
            end else begin
                occ_r <= occ_r;
            end
        end
    end

    // Response registers: loaded leaving LOOKUP, held until the handshake in RESP.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_WIDTH{1'b0}};
            rsp_status_r <= OK;
        end else if (state_r == LOOKUP) begin
            rsp_valid_r  <= 1'b1;
            rsp_data_r   <= rsp_data_next_s;
            rsp_status_r <= rsp_status_next_s;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign req_ready  = ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_status = rsp_status_r;
    assign occupancy  = occ_r;

endmodule

// File: tb/tb_sparce_mem_resp.sv
// Self-checking bench for sparce_mem_resp: vector table plus scoreboard queue.
module tb_sparce_mem_resp;
    import sparceMemPkg::*;

    logic        clk;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    mem_op_e     req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    mem_status_e rsp_status;
    logic [3:0]  occupancy;

    sparce_mem_resp dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .occupancy  (occupancy)
    );

    typedef struct {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
        mem_status_e st;
        logic [31:0] rdata;
        logic [3:0]  occ;
    } vec_t;

    typedef struct {
        mem_status_e st;
        logic [31:0] rdata;
        logic [3:0]  occ;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input mem_op_e op, input logic [31:0] a, input logic [31:0] d,
                                input mem_status_e st, input logic [31:0] rd, input logic [3:0] occ);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.st = st; v.rdata = rd; v.occ = occ;
        vecs.push_back(v);
    endfunction

    // Called just after a negedge; leaves the bench 1ns after the accepting edge.
    task automatic send(input mem_op_e op, input logic [31:0] a, input logic [31:0] d,
                        input mem_status_e st, input logic [31:0] rd, input logic [3:0] occ,
                        input bit push);
        exp_t e;
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        if (push) begin
            e.st = st; e.rdata = rd; e.occ = occ;
            sb.push_back(e);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for the response, checks latency and pops the scoreboard entry.
    task automatic collect(output exp_t e);
        int lat = 0;
        e.st = OK; e.rdata = 32'd0; e.occ = 4'd0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        check("rsp_latency", 32'(lat), 32'd2);
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_status", 32'(rsp_status), 32'(e.st));
            check("rsp_data", rsp_data, e.rdata);
            check("occupancy", 32'(occupancy), 32'(e.occ));
        end else begin
            check("rsp_present", 32'(rsp_valid), 32'd1);
        end
    endtask

    // Completes the handshake and confirms the return to IDLE one cycle later.
    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
        check("req_ready_after_ack", 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input vec_t v);
        exp_t e;
        send(v.op, v.addr, v.data, v.st, v.rdata, v.occ, 1'b1);
        collect(e);
        ack();
    endtask

    initial begin
        exp_t e;
        vec_t v;
        nrst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0;
        req_op = MEM_READ; rsp_ready = 1'b0;

        // Main table: basic ops, fill to full, overwrite, delete, reuse, bad opcode.
        add(MEM_WRITE,  32'hDEAD_0000, 32'h1234_5678, OK,   32'h1234_5678, 4'd1);
        add(MEM_READ,   32'hDEAD_0000, 32'h0,         OK,   32'h1234_5678, 4'd1);
        add(MEM_READ,   32'h0000_0040, 32'h0,         MISS, 32'h0,         4'd1);
        for (int i = 0; i < 7; i++) begin
            add(MEM_WRITE, 32'h1000_0000 + 32'(i * 16), 32'hA000_0000 + 32'(i),
                OK, 32'hA000_0000 + 32'(i), 4'(i + 2));
        end
        add(MEM_WRITE,  32'h5555_0000, 32'h0000_5555, FULL, 32'h0,         4'd8);
        add(MEM_WRITE,  32'hDEAD_0000, 32'hCAFE_F00D, OK,   32'hCAFE_F00D, 4'd8);
        add(MEM_READ,   32'hDEAD_0000, 32'h0,         OK,   32'hCAFE_F00D, 4'd8);
        add(MEM_DELETE, 32'h1000_0010, 32'hFFFF_FFFF, OK,   32'hA000_0001, 4'd7);
        add(MEM_READ,   32'h1000_0010, 32'h0,         MISS, 32'h0,         4'd7);
        add(MEM_DELETE, 32'h1000_0010, 32'h0,         MISS, 32'h0,         4'd7);
        add(MEM_WRITE,  32'h7777_0000, 32'h0BAD_BEEF, OK,   32'h0BAD_BEEF, 4'd8);
        add(MEM_WRITE,  32'h8888_0000, 32'h0000_0001, FULL, 32'h0,         4'd8);
        add(mem_op_e'(2'b11), 32'hDEAD_0000, 32'h0000_0005, ERR, 32'h0,    4'd8);
        add(MEM_DELETE, 32'hDEAD_0000, 32'h0,         OK,   32'hCAFE_F00D, 4'd7);
        add(MEM_READ,   32'hDEAD_0000, 32'h0,         MISS, 32'h0,         4'd7);

        // Reset values while nrst is held low.
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'(OK));
        check("rst_occupancy", 32'(occupancy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready_held", 32'(req_ready), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("req_ready_after_release", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            v = vecs[i];
            txn(v);
        end

        // Lowest free index reuse: slots 0 and 3 free, next writes land in 0 then 3.
        v.op = MEM_DELETE; v.addr = 32'h1000_0020; v.data = 32'h0;
        v.st = OK; v.rdata = 32'hA000_0002; v.occ = 4'd6;
        txn(v);
        v.op = MEM_WRITE; v.addr = 32'h9999_0000; v.data = 32'h0000_0099;
        v.st = OK; v.rdata = 32'h0000_0099; v.occ = 4'd7;
        txn(v);
        check("reuse_slot0_tag", dut.tag_r[0], 32'h9999_0000);
        check("reuse_slot0_valid", 32'(dut.valid_r[0]), 32'd1);
        v.op = MEM_WRITE; v.addr = 32'hAAAA_0000; v.data = 32'h0000_00AA;
        v.st = OK; v.rdata = 32'h0000_00AA; v.occ = 4'd8;
        txn(v);
        check("reuse_slot3_tag", dut.tag_r[3], 32'hAAAA_0000);

        // Backpressure: response held stable for 5 cycles, no new request taken.
        send(MEM_READ, 32'h9999_0000, 32'h0, OK, 32'h0000_0099, 4'd8, 1'b1);
        collect(e);
        req_valid = 1'b1; req_op = MEM_WRITE; req_addr = 32'h1234_0000; req_data = 32'h1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, e.rdata);
            check("bp_rsp_status", 32'(rsp_status), 32'(e.st));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        ack();
        check("bp_occupancy", 32'(occupancy), 32'd8);

        // Reset during the LOOKUP cycle of a WRITE: request dropped, table cleared.
        send(MEM_WRITE, 32'h3333_0000, 32'h3333_3333, OK, 32'h0, 4'd0, 1'b0);
        nrst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_occupancy", 32'(occupancy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("midrst_still_no_rsp", 32'(rsp_valid), 32'd0);
        v.op = MEM_READ; v.addr = 32'h3333_0000; v.data = 32'h0;
        v.st = MISS; v.rdata = 32'h0; v.occ = 4'd0;
        txn(v);
        v.addr = 32'h1000_0000;
        txn(v);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
